instr_issue_queue: RTL and testbench
====================================

# instr_issue_queue

Buffers instructions from the external host in a small synchronous FIFO and issues them one at a time to the processor's control circuit. It holds each instruction word stable for the whole execution and waits for the control circuit's Done before issuing the next. It sits between the external instruction source and the control circuit's INSTRUCTION input, so the host can stream instructions without tracking datapath occupancy.

## Interface
Parameters:
- INSTR_W, 11, instruction width delivered to the control circuit
- DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
- clk  in  1  rising-edge clock; single clock domain
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  host presents in_instr
- in_ready  out  1  queue accepts; equals not full, registered-state only
- in_instr  in  INSTR_W  instruction word from host
- flush  in  1  discard all queued, not-yet-issued entries
- cc_instr  out  INSTR_W  instruction presented to the control circuit
- cc_start  out  1  one-cycle pulse: cc_instr is new, begin execution
- cc_done  in  1  control circuit finished the current instruction
- busy  out  1  an instruction is issued and not yet done
- count  out  $clog2(DEPTH)+1  queued entries, excluding the executing one
- retired_cnt  out  16  retired instruction count (see Configuration)

## Operation
- Push occurs when in_valid and in_ready are both high at a clock edge. in_ready never depends combinationally on pop.
- FSM states:
  - IDLE: if count ≠ 0, pop the head into cc_instr and go to ISSUE.
  - ISSUE: cc_start = 1 for exactly this cycle, then go to EXEC.
  - EXEC: wait for cc_done. On cc_done: if count ≠ 0, pop into cc_instr and go to ISSUE; otherwise go to IDLE.
- busy = 1 in ISSUE and EXEC.
- cc_done is ignored in IDLE and ISSUE.
- cc_instr changes only on a pop edge. It holds its last value in IDLE.
- Simultaneous push and pop: count is unchanged and both take effect.
- Push when full is impossible because in_ready = 0. A pop on the same edge does not raise in_ready until the next cycle.
- flush:
  - Clears the FIFO (count = 0) at the edge.
  - Takes priority over a simultaneous push (the push is dropped) and over a pop (no pop occurs, so EXEC with cc_done goes to IDLE).
  - Does not abort an instruction in ISSUE or EXEC; that instruction still completes and retires.
- Reset values: state IDLE, count 0, pointers 0, cc_instr 0, cc_start 0, busy 0, in_ready 1, retired_cnt 0. Reset mid-execution abandons the instruction; a cc_done arriving after reset is ignored (state IDLE).

## Timing
- Accept at edge E0 into an empty idle queue: pop at E1, cc_start high in the cycle E1–E2, EXEC from E2.
- Back-to-back: cc_done sampled at edge Ek with count ≠ 0 gives a pop at Ek and cc_start in the cycle Ek–Ek+1. Issue-to-issue minimum is therefore 2 cycles when cc_done returns one cycle after cc_start.
- Pointers wrap modulo DEPTH. count spans 0..DEPTH inclusive.
- All outputs are registered, or decoded from registered state only.

## Configuration
- Macro ISSUE_RETIRE_CNT_EN.
- Defined: retired_cnt increments on each cc_done accepted in EXEC. It saturates at 16'hFFFF, is cleared only by reset, and is unaffected by flush.
- Undefined: the counter logic is omitted and retired_cnt is tied to 0. The port list is identical in both builds.

## Structure
- Package issue_pkg holds:
  - FSM state type: IDLE, ISSUE, EXEC
  - default INSTR_W (11) and DEPTH (4)
  - retired-counter width (16)
- One sub-module, issue_fifo: a synchronous FIFO with push, pop, flush, count, full and empty outputs, and the head word. It is parameterised by width and depth.
- The FSM and the retire counter live in instr_issue_queue.

## Test plan
- Push 11'h123 into an idle, empty queue → cc_instr = 11'h123 one edge later, then cc_start pulses exactly 1 cycle, busy = 1; after cc_done: busy = 0, count = 0.
- Push 5 instructions back-to-back with DEPTH = 4 and cc_done held low → in_ready drops once count = 4 with the first instruction executing; the 6th push is stalled. Issue order matches push order.
- cc_done on every EXEC cycle with the queue kept full → a cc_start pulse every 2 cycles; simultaneous push and pop keep count constant.
- flush asserted while in EXEC with 3 queued and in_valid high → count = 0 and the pushed word is dropped. The current instruction still retires and the FSM returns to IDLE.
- reset pulsed during EXEC, then a stray cc_done → all outputs at their reset values and no cc_start. With ISSUE_RETIRE_CNT_EN, retired_cnt = 0.
- With ISSUE_RETIRE_CNT_EN, retired_cnt preloaded near saturation by 65535 retirements → it stays 16'hFFFF after one more cc_done. Without the macro, it stays 0 throughout.

Source files
------------

// File: rtl/instr_issue_queue_pkg.sv
// Shared types and defaults for the instruction issue queue.
// The FSM state type is a plain 2-bit vector with named constants.
package issue_pkg;

    localparam int DEF_INSTR_W = 11;
    localparam int DEF_DEPTH   = 4;
    localparam int RETIRE_W    = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t EXEC  = 2'd2;

endpackage

// File: rtl/instr_issue_queue_if.sv
// Host and control-circuit handshake for the issue queue.
// The slave modport is the queue's view; master is the environment's.
interface instr_issue_queue_if
    import issue_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [INSTR_W-1:0] cc_instr;
    logic               cc_start;
    logic               cc_done;

    modport slave (
        input  in_valid,
        input  in_instr,
        input  cc_done,
        output in_ready,
        output cc_instr,
        output cc_start
    );

    modport master (
        output in_valid,
        output in_instr,
        output cc_done,
        input  in_ready,
        input  cc_instr,
        input  cc_start
    );
endinterface

// File: rtl/instr_issue_queue_fifo.sv
// issue_fifo: synchronous FIFO with flush; push/pop are ignored when full/empty
// and flush wins over both. DEPTH must be a power of two so pointers wrap freely.
module issue_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count/pointers already mark every entry invalid after reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_issue_queue.sv
// Issues queued instructions one at a time to the control circuit, holding each
// word until cc_done. Optional retire counter under `ISSUE_RETIRE_CNT_EN.
module instr_issue_queue
    import issue_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_issue_queue_if.slave     bus,
    input  logic                   flush,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic [RETIRE_W-1:0]    retired_cnt
);
    state_t             state_q, state_d;
    logic [INSTR_W-1:0] cc_instr_q, cc_instr_d;
    logic [INSTR_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               done_ok;
    logic               pop;

    issue_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.in_valid && !fifo_full),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (bus.in_instr),
        .rdata_o (fifo_head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // cc_done only counts while an instruction is actually executing.
    assign done_ok = (state_q == EXEC) && bus.cc_done;
    assign pop     = !flush && !fifo_empty && ((state_q == IDLE) || done_ok);

    always_comb begin
        state_d    = state_q;
        cc_instr_d = cc_instr_q;
        case (state_q)
            IDLE:    if (pop) state_d = ISSUE;
            ISSUE:   state_d = EXEC;
            EXEC:    if (done_ok) state_d = pop ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
        if (pop) cc_instr_d = fifo_head;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cc_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            cc_instr_q <= cc_instr_d;
        end
    end

    assign bus.cc_instr = cc_instr_q;
    assign bus.cc_start = (state_q == ISSUE);
    assign bus.in_ready = !fifo_full;
    assign busy         = (state_q != IDLE);

`ifdef ISSUE_RETIRE_CNT_EN
    logic [RETIRE_W-1:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (done_ok && (retired_q != '1)) retired_d = retired_q + 1'b1;
    end

    // Cleared only by reset; flush leaves the statistic intact.
    always_ff @(posedge clk) begin
        if (reset) retired_q <= '0;
        else       retired_q <= retired_d;
    end

    assign retired_cnt = retired_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a queue-based reference model of the issue rules.
module tb_instr_issue_queue;
    localparam int INSTR_W = 11;
    localparam int DEPTH   = 4;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           flush;
    logic           busy;
    logic [CW-1:0]  count;
    logic [15:0]    retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    instr_issue_queue_if #(.INSTR_W(INSTR_W)) bus ();

    instr_issue_queue #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .flush       (flush),
        .busy        (busy),
        .count       (count),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: pending words, whether one is in flight, whether it was just issued.
    logic [INSTR_W-1:0] mq[$];
    bit                 m_busy     = 1'b0;
    bit                 m_starting = 1'b0;
    logic [INSTR_W-1:0] m_instr    = '0;
    int                 m_retired  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_retired();
`ifdef ISSUE_RETIRE_CNT_EN
        return m_retired;
`else
        return 0;
`endif
    endfunction

    task automatic compare_all();
        check("cc_instr", 32'(bus.cc_instr), 32'(m_instr));
        check("cc_start", 32'(bus.cc_start), 32'(m_starting));
        check("busy", 32'(busy), 32'(m_busy));
        check("count", 32'(count), mq.size());
        check("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        check("retired_cnt", 32'(retired_cnt), exp_retired());
    endtask

    // One clock: sample inputs, advance the model on the edge, compare 1 time unit later.
    task automatic step();
        logic               v = bus.in_valid;
        logic [INSTR_W-1:0] w = bus.in_instr;
        logic               d = bus.cc_done;
        logic               f = flush;
        logic               r = reset;
        int                 pre;
        bit                 done_ok;
        bit                 do_pop;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_busy     = 1'b0;
            m_starting = 1'b0;
            m_instr    = '0;
            m_retired  = 0;
        end else begin
            pre     = mq.size();
            done_ok = m_busy && !m_starting && d;
            if (done_ok && m_retired < 65535) m_retired++;
            m_starting = 1'b0;
            if (done_ok) m_busy = 1'b0;
            if (f) begin
                mq.delete();
            end else begin
                do_pop = !m_busy && pre > 0;
                if (do_pop) begin
                    m_instr    = mq.pop_front();
                    m_busy     = 1'b1;
                    m_starting = 1'b1;
                end
                if (v && pre < DEPTH) mq.push_back(w);
            end
        end
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.cc_done  = 1'b0;
        flush        = 1'b0;
    endtask

    initial begin
        logic [INSTR_W-1:0] issued[$];
        int                 starts;

        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_cc_instr", 32'(bus.cc_instr), 32'd0);

        // Single instruction into an idle, empty queue.
        bus.in_valid = 1'b1;
        bus.in_instr = 11'h123;
        step();
        bus.in_valid = 1'b0;
        step();
        check("t1_cc_instr", 32'(bus.cc_instr), 32'h123);
        check("t1_start", 32'(bus.cc_start), 32'd1);
        step();
        check("t1_start_once", 32'(bus.cc_start), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        bus.cc_done = 1'b1;
        step();
        bus.cc_done = 1'b0;
        check("t1_done_busy", 32'(busy), 32'd0);
        check("t1_done_count", 32'(count), 32'd0);
        step();

        // Six pushes with cc_done low: one executes, four queue, the last stalls.
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = INSTR_W'(11'h200 + i);
            step();
        end
        bus.in_valid = 1'b0;
        check("t2_full_count", 32'(count), 32'd4);
        check("t2_full_ready", 32'(bus.in_ready), 32'd0);
        check("t2_exec_word", 32'(bus.cc_instr), 32'h200);
        bus.cc_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.cc_start) issued.push_back(bus.cc_instr);
        end
        bus.cc_done = 1'b0;
        check("t2_issue_cnt", issued.size(), 32'd4);
        for (int i = 0; i < 4 && i < issued.size(); i++)
            check("t2_order", 32'(issued[i]), 32'h201 + i);
        step();

        // Continuous cc_done and push traffic: steady issue every other cycle.
        bus.in_valid = 1'b1;
        bus.cc_done  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_instr = INSTR_W'($urandom);
            step();
        end
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_instr = INSTR_W'($urandom);
            step();
            if (bus.cc_start) starts++;
        end
        check("t3_start_rate", starts, 32'd10);
        idle_inputs();
        for (int i = 0; i < 12; i++) begin
            bus.cc_done = 1'b1;
            step();
        end
        idle_inputs();
        step();

        // Flush during EXEC with three queued and a simultaneous push.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = INSTR_W'(11'h300 + i);
            step();
        end
        check("t4_pre_count", 32'(count), 32'd3);
        bus.in_instr = 11'h3FF;
        flush        = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("t4_flush_count", 32'(count), 32'd0);
        check("t4_flush_busy", 32'(busy), 32'd1);
        bus.cc_done = 1'b1;
        step();
        bus.cc_done = 1'b0;
        check("t4_retire_idle", 32'(busy), 32'd0);
        step();
        check("t4_no_start", 32'(bus.cc_start), 32'd0);

        // Reset mid-execution, then a stray cc_done.
        bus.in_valid = 1'b1;
        bus.in_instr = 11'h155;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset       = 1'b0;
        bus.cc_done = 1'b1;
        step();
        bus.cc_done = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_start", 32'(bus.cc_start), 32'd0);
        check("t5_instr", 32'(bus.cc_instr), 32'd0);
        check("t5_retired", 32'(retired_cnt), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid = ($urandom_range(99) < 70);
            bus.in_instr = INSTR_W'($urandom);
            bus.cc_done  = ($urandom_range(99) < 40);
            flush        = ($urandom_range(99) < 3);
            reset        = ($urandom_range(199) == 0);
            step();
        end
        idle_inputs();
        reset = 1'b0;
        step();

`ifdef ISSUE_RETIRE_CNT_EN
        // Drive past 65535 retirements to reach saturation.
        reset = 1'b1;
        step();
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.cc_done  = 1'b1;
        while (m_retired < 65535) begin
            bus.in_instr = INSTR_W'($urandom);
            step();
        end
        for (int i = 0; i < 6; i++) step();
        check("t6_saturated", 32'(retired_cnt), 32'hFFFF);
        idle_inputs();
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
